fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that produces the fetch-side inputs of the fetch/decode pipeline register: `instruction`, `pc_f` and `pcPlus4_f`. It generates the sequential PC and issues requests to instruction memory over a request/grant plus response-valid handshake. Returned words are held in a 2-entry in-order fetch queue until decode accepts them. On a taken branch or jump it redirects and discards any responses still in flight.

## Interface
- `DATA_WIDTH`, 32: width of PC and instruction.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0013: bubble word (`addi x0,x0,0`) driven while no valid instruction is available.

Ports (reset is asynchronous and active-low; one clock):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `stall` in 1: decode is holding; the head entry is not consumed.
- `redirect` in 1: a taken branch or jump resolved this cycle.
- `redirect_pc` in DATA_WIDTH: target address, valid when `redirect`=1.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out DATA_WIDTH: request address, word-aligned.
- `imem_gnt` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response data valid; responses return in request order.
- `imem_rdata` in DATA_WIDTH: response instruction word.
- `fetch_valid` out 1: `instruction`, `pc_f` and `pcPlus4_f` are valid.
- `instruction` out DATA_WIDTH: head instruction, or `NOP_INSTR` when not valid.
- `pc_f` out DATA_WIDTH: head PC, or 0 when not valid.
- `pcPlus4_f` out DATA_WIDTH: `pc_f`+4, or 0 when not valid.

## Operation
- **State**
  - `fetch_pc`: next address to request.
  - 2-entry queue. Each entry holds `{pc, instr, filled}`; `occ` ranges 0..2.
  - `drop_cnt` ranges 0..2.
- **Request**
  - `imem_req` = `rst_n` && !`redirect` && `drop_cnt`==0 && (`occ`<2 || `pop`).
  - `imem_addr` = `fetch_pc`.
- **Accept** (`imem_req` && `imem_gnt`)
  - Allocate the tail entry with `pc`=`fetch_pc` and `filled`=0.
  - `fetch_pc` += 4, wrapping modulo 2^DATA_WIDTH.
- **Response** (`imem_rvalid`)
  - If `drop_cnt`>0: discard the response and decrement `drop_cnt`.
  - Otherwise: write `imem_rdata` into the oldest unfilled entry and set `filled`=1.
- **Head and pop**
  - Head valid when `occ`>0 && head `filled`. `fetch_valid` equals head valid; it is a registered-state function, not a bypass of `imem_rvalid`.
  - `pop` = `fetch_valid` && !`stall` && !`redirect`. The head is released at the clock edge.
- **Redirect**, which has highest priority:
  - `fetch_pc` <= `redirect_pc`; queue cleared (`occ`<=0).
  - `drop_cnt` <= number of allocated-but-unfilled entries, minus 1 if `imem_rvalid` is asserted in the same cycle and `drop_cnt`==0. A response arriving in the redirect cycle is discarded.
  - No accept and no pop in the redirect cycle.
- **Simultaneous events:** accept, fill and pop may all occur in one cycle. `occ` <= `occ` + accept − pop.
- **Spurious response:** `imem_rvalid` with no unfilled entry and `drop_cnt`==0 is a protocol error. The data is ignored and the state is unchanged.
- `redirect_pc` low bits [1:0] are forced to 0 in `fetch_pc`.

## Timing
- **Reset values:** `fetch_pc`=`RESET_PC`, `occ`=0, `drop_cnt`=0, `imem_req`=0, `fetch_valid`=0, `instruction`=`NOP_INSTR`, `pc_f`=0, `pcPlus4_f`=0.
- **Reset mid-operation:** all in-flight state is lost. Memory must also be reset.
- **Start-up:** `imem_req`=1 in the first cycle after `rst_n` rises (cycle 0).
  - With `imem_gnt`=1 and 1-cycle memory: accept in cycle 0, `imem_rvalid` in cycle 1, `fetch_valid`=1 in cycle 2.
- **Throughput:** 1 instruction per cycle in steady state with `stall`=0 and 1-cycle memory, because accept is allowed at `occ`==2 when `pop` is asserted.
- **Stall:** outputs hold stable while `stall`=1. `imem_req` drops once `occ`=2 and there is no pop.
- **Redirect penalty:** with `redirect` in cycle N, the target request is in N+1 (if `drop_cnt`=0) and the target appears on `fetch_valid` in N+3.
  - With `drop_cnt`=k, requests resume after k discarded responses.
- `imem_req` and `fetch_valid` are glitch-free functions of registered state plus `stall`/`redirect`. There are no combinational paths from `imem_rdata` to the outputs.

## Test plan
- **Reset and stream:** release reset with `imem_gnt`=1, 1-cycle memory returning addr as data. `fetch_valid` rises in cycle 2 with `pc_f`=0, `instruction`=0, `pcPlus4_f`=4. It then yields PCs 4, 8, 12 on consecutive cycles.
- **Stall hold:** assert `stall` for 4 cycles while `pc_f`=8. Outputs hold at 8. `imem_req`=0 after `occ` reaches 2, no request is lost, and PC 12 follows on release.
- **Redirect with in-flight:** use 3-cycle memory latency and 2 outstanding requests, then `redirect`=1 with `redirect_pc`=0x100. Both stale responses are discarded (`drop_cnt` 2→0). The first valid output is `pc_f`=0x100.
- **Redirect coincident with rvalid and pop:** only the target stream appears afterwards. The same-cycle response never reaches `instruction`.
- **Grant backpressure:** toggle `imem_gnt` randomly at 50%. The PC sequence is contiguous (0, 4, 8, …) with no duplicates or skips. `fetch_valid`=0 cycles output `NOP_INSTR`.
- **Wrap-around:** `redirect_pc`=0xFFFF_FFFC. The next PCs are 0xFFFF_FFFC then 0x0000_0000, and `pcPlus4_f` for the first is 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, req/gnt + rvalid memory handshake,
// a 2-entry in-order fetch queue feeding decode, and redirect with stale-response dropping.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [DATA_WIDTH-1:0] pc_f,
    output logic [DATA_WIDTH-1:0] pcPlus4_f
);

    localparam logic [1:0]            OCC_FULL   = 2'd2;
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

    logic [DATA_WIDTH-1:0]       fetch_pc_q, fetch_pc_d;
    logic [1:0][DATA_WIDTH-1:0]  pc_q, pc_d;
    logic [1:0][DATA_WIDTH-1:0]  instr_q, instr_d;
    logic [1:0]                  filled_q, filled_d;
    logic                        hd_q, hd_d;
    logic [1:0]                  occ_q, occ_d;
    logic [1:0]                  drop_q, drop_d;

    logic                        head_valid_s;
    logic                        pop_s;
    logic                        accept_s;
    logic                        tail_s;
    logic                        fill_hit_s;
    logic                        fill_idx_s;
    logic [1:0]                  unfilled_s;

    assign head_valid_s = (occ_q != 2'd0) && filled_q[hd_q];
    assign pop_s        = head_valid_s && !stall && !redirect;
    assign imem_req     = rst_n && !redirect && (drop_q == 2'd0) && ((occ_q != OCC_FULL) || pop_s);
    assign imem_addr    = fetch_pc_q;
    assign accept_s     = imem_req && imem_gnt;
    // At occ==2 the tail slot is the head slot, which is only reused when it pops this cycle.
    assign tail_s       = hd_q ^ occ_q[0];

    assign fetch_valid  = head_valid_s;
    assign instruction  = head_valid_s ? instr_q[hd_q] : NOP_INSTR;
    assign pc_f         = head_valid_s ? pc_q[hd_q] : {DATA_WIDTH{1'b0}};
    assign pcPlus4_f    = head_valid_s ? (pc_q[hd_q] + PC_STEP) : {DATA_WIDTH{1'b0}};

    // Locate the oldest allocated-but-unfilled entry and count outstanding responses.
    always_comb begin
        fill_hit_s = 1'b0;
        fill_idx_s = hd_q;
        unfilled_s = 2'd0;
        if ((occ_q != 2'd0) && !filled_q[hd_q]) begin
            fill_hit_s = 1'b1;
            fill_idx_s = hd_q;
            unfilled_s = (occ_q == OCC_FULL) ? 2'd2 : 2'd1;
        end else if ((occ_q == OCC_FULL) && !filled_q[~hd_q]) begin
            fill_hit_s = 1'b1;
            fill_idx_s = ~hd_q;
            unfilled_s = 2'd1;
        end else begin
            fill_hit_s = 1'b0;
            fill_idx_s = hd_q;
            unfilled_s = 2'd0;
        end
    end

    // Next-state: redirect flushes everything; otherwise fill, pop and allocate can coincide.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        filled_d   = filled_q;
        hd_d       = hd_q;
        occ_d      = occ_q;
        drop_d     = drop_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ALIGN_MASK;
            occ_d      = 2'd0;
            filled_d   = 2'b00;
            // A response landing this cycle is itself one of the stale ones.
            if (drop_q != 2'd0) begin
                drop_d = drop_q - {1'b0, imem_rvalid};
            end else if (imem_rvalid && fill_hit_s) begin
                drop_d = unfilled_s - 2'd1;
            end else begin
                drop_d = unfilled_s;
            end
        end else begin
            if (imem_rvalid) begin
                if (drop_q != 2'd0) begin
                    drop_d = drop_q - 2'd1;
                end else if (fill_hit_s) begin
                    instr_d[fill_idx_s]  = imem_rdata;
                    filled_d[fill_idx_s] = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end else begin
                drop_d = drop_q;
            end
            if (pop_s) begin
                hd_d = ~hd_q;
            end else begin
                hd_d = hd_q;
            end
            if (accept_s) begin
                pc_d[tail_s]     = fetch_pc_q;
                filled_d[tail_s] = 1'b0;
                fetch_pc_d       = fetch_pc_q + PC_STEP;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            occ_d = occ_q + {1'b0, accept_s} - {1'b0, pop_s};
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            pc_q       <= {(2*DATA_WIDTH){1'b0}};
            instr_q    <= {(2*DATA_WIDTH){1'b0}};
            filled_q   <= 2'b00;
            hd_q       <= 1'b0;
            occ_q      <= 2'd0;
            drop_q     <= 2'd0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            filled_q   <= filled_d;
            hd_q       <= hd_d;
            occ_q      <= occ_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model, architectural PC-stream
// scoreboard, a cycle table for start-up/stall, directed redirect cases and random traffic.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        fetch_valid;
    logic [31:0] instruction;
    logic [31:0] pc_f;
    logic [31:0] pcPlus4_f;

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .fetch_valid(fetch_valid), .instruction(instruction), .pc_f(pc_f), .pcPlus4_f(pcPlus4_f)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          idle = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] key = 32'h0;
    logic        spur = 1'b0;
    logic [31:0] mem_addr[$];
    int          mem_rdy[$];
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_req = 32'h0;
    logic        s_req, s_valid, s_rvalid;
    logic [31:0] s_pc, s_p4;

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive memory response, sample away from the edge, then advance models.
    task automatic tick();
        bit          rv, acc, pop;
        logic [31:0] a;
        rv = (mem_addr.size() > 0) && (mem_rdy[0] <= cyc);
        imem_rvalid = rv || spur;
        imem_rdata  = rv ? data_of(mem_addr[0]) : 32'hDEAD_BEEF;
        #1;
        s_req = imem_req; s_valid = fetch_valid; s_pc = pc_f; s_p4 = pcPlus4_f; s_rvalid = imem_rvalid;
        if (fetch_valid) begin
            check("pc_f", pc_f, exp_pc);
            check("instruction", instruction, data_of(exp_pc));
            check("pcPlus4_f", pcPlus4_f, exp_pc + 32'd4);
        end else begin
            check("bubble_instr", instruction, NOP);
            check("bubble_pc", pc_f, 32'h0);
            check("bubble_pc4", pcPlus4_f, 32'h0);
        end
        if (redirect) check("req_during_redirect", 32'(imem_req), 32'h0);
        acc = imem_req && imem_gnt;
        a   = imem_addr;
        if (acc) check("req_addr", a, exp_req);
        pop = fetch_valid && !stall && !redirect;
        @(posedge clk);
        if (rv) begin
            void'(mem_addr.pop_front());
            void'(mem_rdy.pop_front());
        end
        if (acc) begin
            mem_addr.push_back(a);
            mem_rdy.push_back(cyc + $urandom_range(lat_max, lat_min));
        end
        if (redirect) begin
            exp_pc  = redirect_pc & 32'hFFFF_FFFC;
            exp_req = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (pop) exp_pc = exp_pc + 32'd4;
            if (acc) exp_req = exp_req + 32'd4;
        end
        if (pop || stall || redirect) idle = 0;
        else idle++;
        if (idle > 40) begin
            total++; bad++;
            $display("FAIL liveness: no instruction delivered for %0d cycles (cycle %0d)", idle, cyc);
            idle = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; imem_gnt = 1'b0; spur = 1'b0;
        imem_rvalid = 1'b0;
        mem_addr.delete(); mem_rdy.delete();
        #1;
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(fetch_valid), 32'h0);
        check("rst_instr", instruction, NOP);
        check("rst_pc", pc_f, 32'h0);
        check("rst_pc4", pcPlus4_f, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0; idle = 0; exp_pc = 32'h0; exp_req = 32'h0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        //            stall  req   valid pc
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'd4};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'd8};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'd8};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'd8};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'd8};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'd8};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'd12};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 32'd16};

        @(negedge clk);
        key = 32'h0; lat_min = 1; lat_max = 1;
        do_reset();

        // Start-up stream and 4-cycle stall, 1-cycle memory, grant always.
        for (int i = 0; i < 11; i++) begin
            stall = tbl[i].stall; imem_gnt = 1'b1; redirect = 1'b0;
            tick();
            check("tbl_req", 32'(s_req), 32'(tbl[i].exp_req));
            check("tbl_valid", 32'(s_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check("tbl_pc", s_pc, tbl[i].exp_pc);
                check("tbl_pc4", s_p4, tbl[i].exp_pc + 32'd4);
            end
        end

        // Spurious response while the queue is full and filled: must be ignored.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("spur_hold_req", 32'(s_req), 32'h0);
        stall = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Redirect coincident with a response and a would-be pop.
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        check("coinc_rvalid", 32'(s_rvalid), 32'h1);
        check("coinc_valid", 32'(s_valid), 32'h1);
        tick();
        check("coinc_n1_valid", 32'(s_valid), 32'h0);
        check("coinc_n1_req", 32'(s_req), 32'h1);
        tick();
        check("coinc_n2_valid", 32'(s_valid), 32'h0);
        tick();
        check("coinc_n3_valid", 32'(s_valid), 32'h1);
        check("coinc_n3_pc", s_pc, 32'h0000_0200);
        for (int i = 0; i < 4; i++) tick();

        // Redirect with two requests in flight on 3-cycle memory.
        lat_min = 3; lat_max = 3;
        do_reset();
        imem_gnt = 1'b1;
        tick();
        tick();
        check("inflight_cnt", 32'(mem_addr.size()), 32'd2);
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        tick();
        check("drop1_req", 32'(s_req), 32'h0);
        tick();
        check("drop2_req", 32'(s_req), 32'h0);
        tick();
        check("resume_req", 32'(s_req), 32'h1);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!s_valid && waited < 20);
        check("inflight_wait", 32'(waited), 32'd4);
        check("inflight_first_pc", s_pc, 32'h0000_0100);
        for (int i = 0; i < 6; i++) tick();

        // Wrap-around, with misaligned target bits forced to zero.
        lat_min = 1; lat_max = 1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFD;
        tick();
        redirect = 1'b0;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!s_valid && waited < 20);
        check("wrap_pc", s_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", s_p4, 32'h0);
        tick();
        check("wrap_next_valid", 32'(s_valid), 32'h1);
        check("wrap_next_pc", s_pc, 32'h0);
        for (int i = 0; i < 4; i++) tick();

        // Random traffic with a mid-run reset.
        key = 32'h1357_9BDF; lat_min = 1; lat_max = 3;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            imem_gnt    = ($urandom_range(1, 0) == 1);
            stall       = ($urandom_range(3, 0) == 0);
            redirect    = ($urandom_range(31, 0) == 0);
            redirect_pc = $urandom;
            tick();
        end
        redirect = 1'b0; stall = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
